sdram_aref_sched: RTL and testbench

Parametrised SDRAM auto-refresh scheduler with refresh-debt tracking, postponement and urgent escalation. It replaces the fixed-interval refresh generator in the SDRAM controller and sits beside the init, read and write sub-blocks behind the command arbiter. A free-running interval timer accrues refresh debt. Granted bursts issue PRECHARGE-ALL followed by 1..N AUTO REFRESH commands, retiring debt one refresh at a time.

---
 rtl/sdram_aref_sched.sv | 243 ++++++++++++++++++++++++
 tb/tb_sdram_aref_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_aref_sched.sv
// sdram_aref_sched
// ----------------------------------------------------------------------------
// SDRAM auto-refresh scheduler. A free-running interval timer accrues refresh
// debt once every CLK_PER_REF cycles (while the device is initialised). When
// the command arbiter grants the refresh slot, the block issues a
// PRECHARGE-ALL followed by one or more AUTO REFRESH commands, retiring one
// unit of debt per AUTO REFRESH. Debt beyond URGENT_TH raises aref_urgent so
// the arbiter can pre-empt read/write traffic; a whole outstanding debt is
// then drained in a single burst instead of REF_PER_BURST at a time.
//
// Ports
//   sys_clk     : system clock
//   sys_rst     : synchronous active-high reset
//   init_end    : SDRAM initialisation complete (gates timer and grants)
//   aref_en     : arbiter grant, only looked at while IDLE
//   aref_req    : refresh pending (IDLE, initialised, debt non-zero)
//   aref_urgent : debt at or above URGENT_TH
//   aref_cmd    : {cs_n, ras_n, cas_n, we_n}, registered from the FSM state
//   aref_ba     : bank address, tied to 2'b11
//   aref_addr   : row address, tied to 13'h1fff (A10 high = precharge all)
//   aref_end    : one-cycle pulse when a burst completes
//   aref_debt   : outstanding refresh count
//   aref_ovf    : sticky flag, a tick was lost while debt was saturated
// ----------------------------------------------------------------------------
module sdram_aref_sched #(
    parameter int CLK_PER_REF   = 750,
    parameter int TRP_CLK       = 2,
    parameter int TRC_CLK       = 7,
    parameter int REF_PER_BURST = 2,
    parameter int MAX_DEBT      = 8,
    parameter int URGENT_TH     = 6
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic        aref_urgent,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_ba,
    output logic [12:0] aref_addr,
    output logic        aref_end,
    output logic [3:0]  aref_debt,
    output logic        aref_ovf
);

    localparam int REF_W    = (CLK_PER_REF > 1) ? $clog2(CLK_PER_REF) : 1;
    localparam int WAIT_MAX = (TRP_CLK > TRC_CLK) ? TRP_CLK : TRC_CLK;
    localparam int CLK_W    = $clog2(WAIT_MAX + 1);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PCHA     = 3'd1,
        ST_TRP      = 3'd2,
        ST_AUTO_REF = 3'd3,
        ST_TRF      = 3'd4,
        ST_END      = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [REF_W-1:0]   cnt_ref_r;
    logic [CLK_W-1:0]   cnt_clk_r;
    logic [3:0]         debt_r;
    logic [3:0]         burst_n_r;
    logic [3:0]         issued_r;
    logic               ovf_r;
    logic [3:0]         cmd_r;
    logic               tick_s;
    logic               dec_s;
    logic               wait_end_s;
    logic               grant_s;
    logic               urgent_s;
    logic [3:0]         burst_len_s;

    // Command encoding driven on the bus one cycle after the FSM state.
    function automatic logic [3:0] cmd_of_state(input state_t st);
        logic [3:0] c;
        case (st)
            ST_PCHA:     c = CMD_PRE;
            ST_AUTO_REF: c = CMD_AREF;
            default:     c = CMD_NOP;
        endcase
        return c;
    endfunction

    assign tick_s   = (cnt_ref_r == REF_W'(CLK_PER_REF - 1)) && init_end;
    // debt is never zero in AUTO_REF since n <= debt at grant; the guard
    // only keeps an upset from wrapping the counter.
    assign dec_s    = (state_r == ST_AUTO_REF) && (debt_r != 4'd0);
    assign urgent_s = (debt_r >= 4'(URGENT_TH));
    assign grant_s  = (state_r == ST_IDLE) && (state_nxt_s == ST_PCHA);

    // Burst length chosen at grant time: everything when urgent, else capped.
    assign burst_len_s = urgent_s ? debt_r
                       : ((debt_r < 4'(REF_PER_BURST)) ? debt_r : 4'(REF_PER_BURST));

    // Next-state decode; wait_end_s marks the last cycle of a tRP/tRC wait.
    always_comb begin
        state_nxt_s = state_r;
        wait_end_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (aref_en && init_end && (debt_r != 4'd0)) begin
                    state_nxt_s = ST_PCHA;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PCHA: begin
                state_nxt_s = ST_TRP;
            end
            ST_TRP: begin
                if (cnt_clk_r == CLK_W'(TRP_CLK)) begin
                    wait_end_s  = 1'b1;
                    state_nxt_s = ST_AUTO_REF;
                end else begin
                    state_nxt_s = ST_TRP;
                end
            end
            ST_AUTO_REF: begin
                state_nxt_s = ST_TRF;
            end
            ST_TRF: begin
                if (cnt_clk_r == CLK_W'(TRC_CLK)) begin
                    wait_end_s = 1'b1;
                    if (issued_r < burst_n_r) begin
                        state_nxt_s = ST_AUTO_REF;
                    end else begin
                        state_nxt_s = ST_END;
                    end
                end else begin
                    state_nxt_s = ST_TRF;
                end
            end
            ST_END: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Refresh interval timer; holds while the device is not initialised.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_ref_r <= '0;
        end else if (init_end) begin
            if (cnt_ref_r == REF_W'(CLK_PER_REF - 1)) begin
                cnt_ref_r <= '0;
            end else begin
                cnt_ref_r <= cnt_ref_r + REF_W'(1);
            end
        end else begin
            cnt_ref_r <= cnt_ref_r;
        end
    end

    // Wait counter for tRP / tRC; only runs inside the two wait states.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_clk_r <= '0;
        end else if (((state_r == ST_TRP) || (state_r == ST_TRF)) && !wait_end_s) begin
            cnt_clk_r <= cnt_clk_r + CLK_W'(1);
        end else begin
            cnt_clk_r <= '0;
        end
    end

    // Refresh debt: a tick and a retirement in the same cycle cancel out.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            debt_r <= 4'd0;
            ovf_r  <= 1'b0;
        end else begin
            case ({tick_s, dec_s})
                2'b10: begin
                    if (debt_r >= 4'(MAX_DEBT)) begin
                        ovf_r <= 1'b1;
                    end else begin
                        debt_r <= debt_r + 4'd1;
                    end
                end
                2'b01: begin
                    debt_r <= debt_r - 4'd1;
                end
                default: begin
                    debt_r <= debt_r;
                end
            endcase
        end
    end

    // Burst length latch and count of AUTO REFRESH commands issued so far.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            burst_n_r <= 4'd0;
            issued_r  <= 4'd0;
        end else if (grant_s) begin
            burst_n_r <= burst_len_s;
            issued_r  <= 4'd0;
        end else if (state_r == ST_AUTO_REF) begin
            issued_r  <= issued_r + 4'd1;
        end else begin
            issued_r  <= issued_r;
        end
    end

    // Registered command bus.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cmd_r <= CMD_NOP;
        end else begin
            cmd_r <= cmd_of_state(state_r);
        end
    end

    // Status outputs are pure decodes of registered state (plus init_end for
    // the request), so the grant has no combinational path back to them.
    assign aref_req    = (state_r == ST_IDLE) && init_end && (debt_r != 4'd0);
    assign aref_urgent = urgent_s;
    assign aref_end    = (state_r == ST_END);
    assign aref_cmd    = cmd_r;
    assign aref_ba     = 2'b11;
    assign aref_addr   = 13'h1fff;
    assign aref_debt   = debt_r;
    assign aref_ovf    = ovf_r;

endmodule

// File: tb/tb_sdram_aref_sched.sv
// Bench for sdram_aref_sched. The refresh interval is set longer than the
// longest burst, so debt does not accrue while a burst is running unless a
// test aligns a tick on purpose.
module tb_sdram_aref_sched;

    localparam int CLK_PER_REF   = 100;
    localparam int TRP_CLK       = 2;
    localparam int TRC_CLK       = 7;
    localparam int REF_PER_BURST = 2;
    localparam int MAX_DEBT      = 8;
    localparam int URGENT_TH     = 6;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] EV_END   = 4'b1111;

    logic        sys_clk;
    logic        sys_rst;
    logic        init_end;
    logic        aref_en;
    logic        aref_req;
    logic        aref_urgent;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [12:0] aref_addr;
    logic        aref_end;
    logic [3:0]  aref_debt;
    logic        aref_ovf;

    sdram_aref_sched #(
        .CLK_PER_REF  (CLK_PER_REF),
        .TRP_CLK      (TRP_CLK),
        .TRC_CLK      (TRC_CLK),
        .REF_PER_BURST(REF_PER_BURST),
        .MAX_DEBT     (MAX_DEBT),
        .URGENT_TH    (URGENT_TH)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .init_end   (init_end),
        .aref_en    (aref_en),
        .aref_req   (aref_req),
        .aref_urgent(aref_urgent),
        .aref_cmd   (aref_cmd),
        .aref_ba    (aref_ba),
        .aref_addr  (aref_addr),
        .aref_end   (aref_end),
        .aref_debt  (aref_debt),
        .aref_ovf   (aref_ovf)
    );

    typedef struct {
        logic [3:0] kind;
        int         at;
    } ev_t;

    typedef struct {
        int k;        // intervals withheld before the grant
        int debt_b;   // expected debt at grant
        int urg_b;
        int ovf_b;
        int n;        // expected AUTO REFRESH count in the burst
        int debt_a;   // expected debt after the burst
        int req_a;
        int ovf_a;
    } vec_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   k0 = 0;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Edge counter: after "@(posedge); #1" cyc is the index of that edge.
    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    // Scoreboard monitor: every command or end pulse must match the head
    // of the expected queue in kind and cycle.
    initial forever begin
        @(negedge sys_clk);
        if ((aref_cmd != CMD_NOP) || aref_end) begin
            automatic logic [3:0] k = aref_end ? EV_END : aref_cmd;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL event_unexpected: got kind %b at cycle %0d, required no event", k, cyc);
            end else begin
                automatic ev_t e = exp_q.pop_front();
                if ((e.kind !== k) || (e.at != cyc)) begin
                    n_fail++;
                    $display("FAIL event: got kind %b at cycle %0d, required kind %b at cycle %0d",
                             k, cyc, e.kind, e.at);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic clk();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) clk();
    endtask

    function automatic int tick_edge(input int m);
        return k0 + CLK_PER_REF - 1 + CLK_PER_REF * m;
    endfunction

    // Cycle of the aref_end pulse for a burst granted at edge g.
    function automatic int end_at(input int g, input int n);
        return g + 1 + (TRP_CLK + 2) + (TRC_CLK + 2) * (n - 1) + (TRC_CLK + 1);
    endfunction

    task automatic push_burst(input int g, input int n);
        exp_q.push_back('{CMD_PRE, g + 1});
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{CMD_AREF, g + 1 + (TRP_CLK + 2) + (TRC_CLK + 2) * i});
        end
        exp_q.push_back('{EV_END, end_at(g, n)});
    endtask

    task automatic start_test();
        sys_rst  = 1'b1;
        init_end = 1'b0;
        aref_en  = 1'b0;
        clk();
        exp_q.delete();
        sys_rst  = 1'b0;
        init_end = 1'b1;
        k0 = cyc + 1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},    aref_req, 0);
        check({tag, "_urgent"}, aref_urgent, 0);
        check({tag, "_cmd"},    aref_cmd, CMD_NOP);
        check({tag, "_ba"},     aref_ba, 2'b11);
        check({tag, "_addr"},   aref_addr, 13'h1fff);
        check({tag, "_end"},    aref_end, 0);
        check({tag, "_debt"},   aref_debt, 0);
        check({tag, "_ovf"},    aref_ovf, 0);
    endtask

    // One-cycle grant sampled at edge g; returns once the FSM is back in IDLE.
    task automatic grant_at(input int g, input int n);
        wait_to(g - 1);
        aref_en = 1'b1;
        push_burst(g, n);
        clk();
        aref_en = 1'b0;
        check("req_drop_on_grant", aref_req, 0);
        wait_to(end_at(g, n) + 1);
        check("burst_events_done", exp_q.size(), 0);
    endtask

    vec_t vecs[6];

    initial begin
        int g;
        int held;
        int r;

        vecs[0] = '{1, 1, 0, 0, 1, 0, 0, 0};
        vecs[1] = '{5, 5, 0, 0, 2, 3, 1, 0};
        vecs[2] = '{6, 6, 1, 0, 6, 0, 0, 0};
        vecs[3] = '{9, 8, 1, 1, 8, 0, 0, 1};
        vecs[4] = '{3, 3, 0, 0, 2, 1, 1, 0};
        vecs[5] = '{7, 7, 1, 0, 7, 0, 0, 0};

        sys_rst  = 1'b1;
        init_end = 1'b0;
        aref_en  = 1'b0;
        clk();
        check_reset_values("reset");

        // Table: withhold the grant k intervals, then grant once.
        for (int v = 0; v < 6; v++) begin
            start_test();
            g = tick_edge(vecs[v].k - 1) + 1;
            wait_to(g - 1);
            check("vec_debt_before",   aref_debt,   vecs[v].debt_b);
            check("vec_urgent_before", aref_urgent, vecs[v].urg_b);
            check("vec_ovf_before",    aref_ovf,    vecs[v].ovf_b);
            check("vec_req_before",    aref_req,    1);
            grant_at(g, vecs[v].n);
            check("vec_debt_after",    aref_debt,   vecs[v].debt_a);
            check("vec_req_after",     aref_req,    vecs[v].req_a);
            check("vec_ovf_after",     aref_ovf,    vecs[v].ovf_a);
            check("vec_urgent_after",  aref_urgent, (vecs[v].debt_a >= URGENT_TH) ? 1 : 0);
            check("vec_cmd_after",     aref_cmd,    CMD_NOP);
        end

        // Grant held high: each tick is served by its own one-refresh burst.
        start_test();
        aref_en = 1'b1;
        push_burst(tick_edge(0) + 1, 1);
        push_burst(tick_edge(1) + 1, 1);
        wait_to(tick_edge(0) - 1);
        check("cont_debt0", aref_debt, 0);
        check("cont_req0", aref_req, 0);
        clk();
        check("cont_debt1", aref_debt, 1);
        wait_to(tick_edge(0) + 6);
        check("cont_debt_retired", aref_debt, 0);
        wait_to(end_at(tick_edge(1) + 1, 1) + 2);
        aref_en = 1'b0;
        check("cont_events_done", exp_q.size(), 0);

        // Postpone: two bursts of REF_PER_BURST drain 5 -> 3 -> 1.
        start_test();
        g = tick_edge(4) + 1;
        grant_at(g, 2);
        check("postpone_debt3", aref_debt, 3);
        check("postpone_req", aref_req, 1);
        grant_at(cyc + 1, 2);
        check("postpone_debt1", aref_debt, 1);
        check("postpone_req2", aref_req, 1);

        // Tick lands on the same edge as the only AUTO REFRESH retirement.
        start_test();
        g = tick_edge(1) - 5;
        wait_to(g - 1);
        check("simul_debt_before", aref_debt, 1);
        grant_at(g, 1);
        check("simul_debt_after", aref_debt, 1);
        check("simul_ovf", aref_ovf, 0);
        check("simul_req", aref_req, 1);

        // Reset during the first tRC wait: no further commands afterwards.
        start_test();
        g = tick_edge(1) + 1;
        wait_to(g - 1);
        aref_en = 1'b1;
        exp_q.push_back('{CMD_PRE, g + 1});
        exp_q.push_back('{CMD_AREF, g + 1 + (TRP_CLK + 2)});
        clk();
        aref_en = 1'b0;
        wait_to(g + 7);
        sys_rst = 1'b1;
        clk();
        check_reset_values("midburst_rst");
        sys_rst  = 1'b0;
        init_end = 1'b0;
        wait_to(cyc + 40);
        check("midburst_rst_no_events", exp_q.size(), 0);
        check("midburst_rst_cmd", aref_cmd, CMD_NOP);

        // init_end falls during a burst: it completes, then the timer holds.
        start_test();
        g = tick_edge(1) + 1;
        wait_to(g - 1);
        aref_en = 1'b1;
        push_burst(g, 2);
        clk();
        aref_en = 1'b0;
        wait_to(g + 3);
        init_end = 1'b0;
        held = (g + 3 - k0 + 1) % CLK_PER_REF;
        wait_to(end_at(g, 2) + 1);
        check("initdrop_events_done", exp_q.size(), 0);
        check("initdrop_debt", aref_debt, 0);
        check("initdrop_req", aref_req, 0);
        wait_to(cyc + 2 * CLK_PER_REF);
        check("initdrop_timer_held", aref_debt, 0);
        init_end = 1'b1;
        r = cyc + 1;
        wait_to(r + CLK_PER_REF - 1 - held - 1);
        check("resume_debt_before_tick", aref_debt, 0);
        clk();
        check("resume_debt_after_tick", aref_debt, 1);
        check("resume_req", aref_req, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
